// File: rtl/snail_pattern_fsm.sv
// Serial pattern detector: flags each occurrence of PATTERN in the en-qualified bit stream a,
// with selectable Mealy/Moore output timing, overlap mode and a saturating match counter.
`timescale 1ns/1ps
module snail_pattern_fsm #(
    parameter int              LEN     = 4,
    parameter logic [LEN-1:0]  PATTERN = 4'b1011,
    parameter int              OVERLAP = 1,
    parameter int              MOORE   = 0,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                FILL_W   = $clog2(LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

    generate
        if (LEN < 2 || LEN > 32) begin : g_bad_len
            $error("snail_pattern_fsm: LEN must be in 2..32");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("snail_pattern_fsm: CNT_W must be at least 1");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [LEN-2:0]    hist;
    logic [FILL_W-1:0] fill;
    logic              y_reg;
    logic [LEN-1:0]    win;
    logic              hit;

    // The completing bit is still present on a, so a match is visible before the edge that samples it.
    assign win = {hist, a};
    assign hit = en & (fill == FILL_MAX) & (win == PATTERN);
    assign y   = (MOORE != 0) ? y_reg : hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            y_reg     <= 1'b0;
            match_cnt <= '0;
        end else if (en) begin
            hist  <= win[LEN-2:0];
            y_reg <= hit;
            // Non-overlap consumes the completing bit: the next window must be built from fresh samples.
            if (hit && OVERLAP == 0)
                fill <= '0;
            else if (fill != FILL_MAX)
                fill <= fill + FILL_W'(1);
            if (clr)
                match_cnt <= '0;
            else if (hit)
                match_cnt <= sat_inc(match_cnt);
        end
    end

endmodule

// File: tb/tb_snail_pattern_fsm.sv
// Bench for snail_pattern_fsm: four configurations share one stimulus stream and are compared
// against a queue-based reference model of the pattern-matching rules.
`timescale 1ns/1ps
module tb_snail_pattern_fsm;

    localparam int             LEN = 4;
    localparam logic [LEN-1:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic a   = 1'b0;
    logic clr = 1'b0;

    logic       y_ov, y_nov, y_mo, y_sat;
    logic [7:0] cnt_ov, cnt_nov, cnt_mo;
    logic [1:0] cnt_sat;

    int total = 0;
    int bad   = 0;

    // Reference state: bits sampled since the last restart, oldest first.
    bit q_ov[$];
    bit q_nov[$];
    int c_ov, c_nov, c_sat;
    bit mo_reg;

    always #5 clk = ~clk;

    snail_pattern_fsm #(.LEN(LEN), .PATTERN(PAT), .OVERLAP(1), .MOORE(0), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr), .y(y_ov), .match_cnt(cnt_ov));
    snail_pattern_fsm #(.LEN(LEN), .PATTERN(PAT), .OVERLAP(0), .MOORE(0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr), .y(y_nov), .match_cnt(cnt_nov));
    snail_pattern_fsm #(.LEN(LEN), .PATTERN(PAT), .OVERLAP(1), .MOORE(1), .CNT_W(8)) u_mo (
        .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr), .y(y_mo), .match_cnt(cnt_mo));
    snail_pattern_fsm #(.LEN(LEN), .PATTERN(PAT), .OVERLAP(1), .MOORE(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .a(a), .clr(clr), .y(y_sat), .match_cnt(cnt_sat));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // True when the last LEN-1 recorded bits followed by b spell the pattern.
    function automatic bit tail_match(input bit q[$], input bit b);
        int n;
        n = q.size();
        if (n < LEN - 1) return 1'b0;
        for (int i = 0; i < LEN - 1; i++)
            if (q[n - (LEN - 1) + i] != PAT[LEN - 1 - i]) return 1'b0;
        return b == PAT[0];
    endfunction

    function automatic int bump(input int c, input int maxv);
        return (c >= maxv) ? maxv : c + 1;
    endfunction

    task automatic model_reset();
        q_ov.delete();
        q_nov.delete();
        c_ov   = 0;
        c_nov  = 0;
        c_sat  = 0;
        mo_reg = 1'b0;
    endtask

    task automatic step(input logic e, input logic b, input logic c);
        bit h_ov, h_nov;
        @(negedge clk);
        en = e; a = b; clr = c;
        #1;
        h_ov  = e && tail_match(q_ov, b);
        h_nov = e && tail_match(q_nov, b);
        chk("y_ov", {31'b0, y_ov}, {31'b0, h_ov});
        chk("y_nov", {31'b0, y_nov}, {31'b0, h_nov});
        chk("y_moore", {31'b0, y_mo}, {31'b0, mo_reg});
        chk("y_sat", {31'b0, y_sat}, {31'b0, h_ov});
        chk("cnt_ov", {24'b0, cnt_ov}, c_ov);
        chk("cnt_nov", {24'b0, cnt_nov}, c_nov);
        chk("cnt_moore", {24'b0, cnt_mo}, c_ov);
        chk("cnt_sat", {30'b0, cnt_sat}, c_sat);
        @(posedge clk);
        if (e) begin
            if (c) begin
                c_ov = 0; c_nov = 0; c_sat = 0;
            end else begin
                if (h_ov)  c_ov  = bump(c_ov, 255);
                if (h_nov) c_nov = bump(c_nov, 255);
                if (h_ov)  c_sat = bump(c_sat, 3);
            end
            mo_reg = h_ov;
            q_ov.push_back(b);
            q_nov.push_back(b);
            if (h_nov) q_nov.delete();
            if (q_ov.size() > 64) void'(q_ov.pop_front());
            if (q_nov.size() > 64) void'(q_nov.pop_front());
        end
    endtask

    // Reset asserted away from any edge, with busy inputs, and held across a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1; en = 1'b1; a = 1'b1; clr = 1'b0;
        #1;
        model_reset();
        chk("rst_y_ov", {31'b0, y_ov}, 0);
        chk("rst_y_moore", {31'b0, y_mo}, 0);
        chk("rst_cnt_ov", {24'b0, cnt_ov}, 0);
        chk("rst_cnt_sat", {30'b0, cnt_sat}, 0);
        @(negedge clk);
        chk("rst_hold_y_nov", {31'b0, y_nov}, 0);
        rst = 1'b0; en = 1'b0; a = 1'b0;
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0);
    endtask

    initial begin
        // Overlap vs non-overlap and Moore timing on 1,0,1,1,0,1,1.
        do_reset();
        stream(16'b1011011, 7);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("dir_moore_hold", {31'b0, y_mo}, 1);
        chk("dir_cnt_ov_2", {24'b0, cnt_ov}, 2);
        chk("dir_cnt_nov_1", {24'b0, cnt_nov}, 1);

        // Enable gating: en every third clock, garbage on a and clr otherwise.
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] p;
            p = PAT;
            step(1'b1, p[i], 1'b0);
            step(1'b0, 1'($urandom), 1'($urandom));
            step(1'b0, 1'($urandom), 1'($urandom));
        end
        chk("dir_gated_cnt", {24'b0, cnt_ov}, 1);

        // Saturation with five overlapping matches, then clr on a completing edge.
        do_reset();
        stream(16'b1011011011011011, 16);
        step(1'b0, 1'b0, 1'b0);
        chk("dir_sat_3", {30'b0, cnt_sat}, 3);
        chk("dir_cnt_ov_5", {24'b0, cnt_ov}, 5);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("dir_clr_sat", {30'b0, cnt_sat}, 0);
        chk("dir_clr_ov", {24'b0, cnt_ov}, 0);

        // Reset mid-pattern discards the partial history.
        do_reset();
        stream(16'b101, 3);
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        chk("dir_no_match_after_rst", {24'b0, cnt_ov}, 0);
        stream(16'b011, 3);
        step(1'b0, 1'b0, 1'b0);
        chk("dir_match_after_rst", {24'b0, cnt_ov}, 1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 40) == 0);
        step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snail_pattern_fsm.md
Name: snail_pattern_fsm

Overview:
Parametrised serial pattern detector, the successor to the fixed-sequence "snail" FSM used in the 1_basics labs. It watches a 1-bit stream `a`, sampled only on enabled clock edges, and flags every occurrence of a compile-time bit pattern of configurable length. Build-time parameters select Mealy or Moore output timing and overlapping or non-overlapping detection. A saturating match counter drives board LEDs and seven-segment displays.

Parameters:
LEN, 4, pattern length in bits; legal range 2..32.
PATTERN, 4'b1011, pattern bits; PATTERN[LEN-1] is the first (oldest) bit received, PATTERN[0] the last.
OVERLAP, 1, 1 = matches may share bits; 0 = after a match, detection restarts from an empty history.
MOORE, 0, 0 = combinational Mealy output; 1 = registered Moore output.
CNT_W, 8, width of match counter.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
en   input  1  sample strobe; state advances only on posedge clk with en=1
a    input  1  serial data bit
clr  input  1  synchronous clear of match_cnt, qualified by en
y    output 1  match indication
match_cnt  output CNT_W  number of matches since reset or clr, saturating

Behaviour:
- Reset (async): history register = 0, fill counter = 0, y_reg = 0, match_cnt = 0. Output y = 0 while rst is high in both modes.
- State held:
  - hist[LEN-2:0]: the last LEN-1 sampled bits, newest bit in bit 0.
  - fill: count of valid history bits, width $clog2(LEN), saturates at LEN-1.
- Candidate window: win = {hist[LEN-2:0], a}.
- hit = en & (fill == LEN-1) & (win == PATTERN). hit is purely combinational.
- On posedge clk with en=1:
  - hist shifts left by one and takes `a` into bit 0.
  - If hit & OVERLAP=0: fill <= 0.
  - Otherwise fill <= min(fill+1, LEN-1).
- With en=0, all state holds. A toggling `a` has no effect and cannot produce a hit.
- Mealy (MOORE=0): y = hit. High in the same cycle that the completing bit is present with en=1, before the edge samples it.
- Moore (MOORE=1):
  - y_reg <= hit on every en edge and holds between en edges.
  - y = y_reg, so y rises one en-sample after the Mealy timing.
  - y stays high for exactly one en-period unless the next sample also matches (e.g. pattern 1111 with OVERLAP=1).
- Counter, on an en edge:
  - clr=1: match_cnt <= 0. clr wins over a simultaneous hit; that hit is not counted, but history/fill/y behave normally.
  - Else if hit: match_cnt <= match_cnt+1, saturating at all-ones (no wrap).
  - clr with en=0 has no effect.
- Reset mid-stream: partial history is discarded. The first match after reset needs LEN fresh samples.
- Non-overlap boundary: the completing bit of a match is consumed. It is not part of the next window, although it is still shifted into hist.
- Elaboration: LEN<2, LEN>32, or CNT_W<1 must trigger an elaboration-time error ($error in a generate block).

Test Plan:
- Overlap, Mealy: LEN=4, PATTERN=1011, OVERLAP=1, en=1 every cycle, a=1,0,1,1,0,1,1.
  - y high during samples 4 and 7.
  - match_cnt=2.
- Non-overlap: same stream with OVERLAP=0.
  - y high during sample 4 only.
  - match_cnt=1.
- Moore timing: MOORE=1, a=1,0,1,1,0.
  - y low during sample 4, high during sample 5 (one en-period).
  - y still high while en is held low for 3 cycles afterwards.
- Enable gating: en asserted every 3rd clk, a=1,0,1,1 presented on those en cycles with garbage on the others.
  - Exactly one match, counted as match_cnt=1.
- Counter: CNT_W=2, stream of 5 matches.
  - match_cnt=3 (saturated).
  - Then clr=1 on an en edge that also completes a match: match_cnt=0.
- Async reset: assert rst mid-pattern after a=1,0,1, release, then a=1.
  - No match.
  - A full 1,0,1,1 after release gives y=1 and match_cnt=1.
